if_stage: RTL and testbench

Instruction-fetch stage of the GeMIPS five-stage pipeline, directly upstream of the decode stage. Holds the program counter, drives the instruction-ROM read port, and registers the fetched `{pc, inst}` pair into the IF/ID pipeline register consumed by decode. It applies decode's branch redirect with MIPS delay-slot semantics and inserts load-use bubbles when decode raises its stop request. It also honours a global pipeline hold.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 36 +++
 rtl/if_stage.sv | 104 ++++++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the GeMIPS instruction-fetch stage.
// State encodings are plain constants so older tooling can consume them unchanged.
package if_stage_pkg;

   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] ADDR_ALIGN_MASK  = 32'hFFFF_FFFC;

   localparam int STALL_CNT_W = 3;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched {pc, inst}, injects a bubble, or holds.
// A bubble clears both fields so decode sees a clean sll $0,$0,0.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        bubble_i,
   input  if_id_t      fetch_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        bubble_o
);

   if_id_t data_q;
   logic   bubble_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '{pc: 32'h0, inst: INST_NOP};
         bubble_q <= 1'b1;
      end else if (bubble_i) begin
         data_q   <= '{pc: 32'h0, inst: INST_NOP};
         bubble_q <= 1'b1;
      end else if (load_i) begin
         data_q   <= fetch_i;
         bubble_q <= 1'b0;
      end
   end

   assign id_pc_o   = data_q.pc;
   assign id_inst_o = data_q.inst;
   assign bubble_o  = bubble_q;

endmodule

// File: rtl/if_stage.sv
// GeMIPS instruction fetch: PC register, BOOT/RUN/STALL control and the IF/ID register.
// Branches keep the delay slot; load-use stops refetch the held PC after the bubbles.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC          = RESET_PC_DEFAULT,
   parameter int          LOAD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_flag_i,
   input  logic [31:0] target_address_i,
   input  logic        stop_req_i,
   input  logic        ext_stall_i,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        bubble_o
);

   localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [STALL_CNT_W-1:0] CNT_ONE    = STALL_CNT_W'(1);

   logic [31:0]            pc_q, pc_d;
   logic [1:0]             state_q, state_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic                   ifid_load;
   logic                   ifid_bubble;
   if_id_t                 fetch;

   assign rom_addr_o = pc_q;
   assign rom_ce_o   = (state_q != ST_BOOT);
   assign fetch      = '{pc: pc_q, inst: rom_data_i};

   // Holding is the default; ext_stall_i simply suppresses every update below.
   always_comb begin
      pc_d        = pc_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      case (state_q)
         ST_BOOT: begin
            ifid_bubble = 1'b1;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            if (ext_stall_i) begin
               ifid_load = 1'b0;
            end else if (branch_flag_i) begin
               ifid_load = 1'b1;
               pc_d      = target_address_i & ADDR_ALIGN_MASK;
            end else if (stop_req_i) begin
               ifid_bubble = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_d = ST_STALL;
                  cnt_d   = STALL_INIT;
               end
            end else begin
               ifid_load = 1'b1;
               pc_d      = pc_q + 32'd4;
            end
         end
         ST_STALL: begin
            if (!ext_stall_i) begin
               ifid_bubble = 1'b1;
               cnt_d       = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_BOOT;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .load_i    (ifid_load),
      .bubble_i  (ifid_bubble),
      .fetch_i   (fetch),
      .id_pc_o   (id_pc_o),
      .id_inst_o (id_inst_o),
      .bubble_o  (bubble_o)
   );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a vector table for the default configuration,
// plus hand-written sequences for the 3-bubble stall, mid-stall reset and PC wrap.
module tb_if_stage;

   localparam logic [31:0] D = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic        stop = 1'b0;
   logic        ext = 1'b0;

   logic [31:0] addr1, data1, pc1, inst1;
   logic        ce1, bub1;
   logic [31:0] addr3, data3, pc3, inst3;
   logic        ce3, bub3;
   logic [31:0] addrw, dataw, pcw, instw;
   logic        cew, bubw;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   assign data1 = rom_f(addr1);
   assign data3 = rom_f(addr3);
   assign dataw = rom_f(addrw);

   if_stage #(.RESET_PC(32'h8000_0000), .LOAD_STALL_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .branch_flag_i(br), .target_address_i(tgt),
      .stop_req_i(stop), .ext_stall_i(ext), .rom_addr_o(addr1), .rom_ce_o(ce1),
      .rom_data_i(data1), .id_pc_o(pc1), .id_inst_o(inst1), .bubble_o(bub1)
   );

   if_stage #(.RESET_PC(32'h8000_0000), .LOAD_STALL_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .branch_flag_i(br), .target_address_i(tgt),
      .stop_req_i(stop), .ext_stall_i(ext), .rom_addr_o(addr3), .rom_ce_o(ce3),
      .rom_data_i(data3), .id_pc_o(pc3), .id_inst_o(inst3), .bubble_o(bub3)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8), .LOAD_STALL_CYCLES(1)) dutw (
      .clk(clk), .rst(rst), .branch_flag_i(br), .target_address_i(tgt),
      .stop_req_i(stop), .ext_stall_i(ext), .rom_addr_o(addrw), .rom_ce_o(cew),
      .rom_data_i(dataw), .id_pc_o(pcw), .id_inst_o(instw), .bubble_o(bubw)
   );

   typedef struct {
      logic        rst;
      logic        br;
      logic [31:0] tgt;
      logic        stop;
      logic        ext;
      logic        ce;
      logic [31:0] addr;
      logic        pc_chk;
      logic [31:0] pc;
      logic        bub;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                               input logic s, input logic e, input logic c,
                               input logic [31:0] a, input logic pk,
                               input logic [31:0] p, input logic bb);
      vec_t v;
      v.rst = r; v.br = b; v.tgt = t; v.stop = s; v.ext = e;
      v.ce = c; v.addr = a; v.pc_chk = pk; v.pc = p; v.bub = bb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compares one DUT's outputs; the expected instruction comes from the bench ROM model.
   task automatic exp_out(input string tag,
                          input logic ce_a, input logic [31:0] addr_a,
                          input logic [31:0] pc_a, input logic [31:0] inst_a,
                          input logic bub_a,
                          input logic ce_e, input logic [31:0] addr_e,
                          input logic pc_chk, input logic [31:0] pc_e,
                          input logic bub_e);
      chk({tag, " ce"}, {31'h0, ce_a}, {31'h0, ce_e});
      chk({tag, " rom_addr"}, addr_a, addr_e);
      if (pc_chk) chk({tag, " id_pc"}, pc_a, pc_e);
      chk({tag, " id_inst"}, inst_a, bub_e ? 32'h0 : rom_f(pc_e));
      chk({tag, " bubble"}, {31'h0, bub_a}, {31'h0, bub_e});
      $display("[TB] %s addr=%h id_pc=%h id_inst=%h bubble=%0b", tag, addr_a, pc_a, inst_a, bub_a);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           rst br tgt          stop ext  ce addr       pk pc         bub
      tbl[0]  = mk(0, 0, 32'h0,       0, 0,   0, D,         1, 32'h0,     1);
      tbl[1]  = mk(0, 0, 32'h0,       0, 0,   1, D,         0, 32'h0,     1);
      tbl[2]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h04,  1, D,         0);
      tbl[3]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h08,  1, D+32'h04,  0);
      tbl[4]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h0C,  1, D+32'h08,  0);
      tbl[5]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h10,  1, D+32'h0C,  0);
      tbl[6]  = mk(0, 1, D+32'h100,   0, 0,   1, D+32'h14,  1, D+32'h10,  0);
      tbl[7]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h100, 1, D+32'h14,  0);
      tbl[8]  = mk(0, 1, D+32'h103,   0, 0,   1, D+32'h104, 1, D+32'h100, 0);
      tbl[9]  = mk(0, 0, 32'h0,       0, 0,   1, D+32'h100, 1, D+32'h104, 0);
      tbl[10] = mk(0, 1, D+32'h1C,    0, 0,   1, D+32'h104, 1, D+32'h100, 0);
      tbl[11] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h1C,  1, D+32'h104, 0);
      tbl[12] = mk(0, 0, 32'h0,       1, 0,   1, D+32'h20,  1, D+32'h1C,  0);
      tbl[13] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h20,  0, 32'h0,     1);
      tbl[14] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h24,  1, D+32'h20,  0);
      tbl[15] = mk(0, 0, 32'h0,       0, 1,   1, D+32'h28,  1, D+32'h24,  0);
      tbl[16] = mk(0, 0, 32'h0,       0, 1,   1, D+32'h28,  1, D+32'h24,  0);
      tbl[17] = mk(0, 0, 32'h0,       0, 1,   1, D+32'h28,  1, D+32'h24,  0);
      tbl[18] = mk(0, 0, 32'h0,       0, 1,   1, D+32'h28,  1, D+32'h24,  0);
      tbl[19] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h28,  1, D+32'h24,  0);
      tbl[20] = mk(0, 0, 32'h0,       1, 1,   1, D+32'h2C,  1, D+32'h28,  0);
      tbl[21] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h2C,  1, D+32'h28,  0);
      tbl[22] = mk(0, 1, D+32'h200,   1, 0,   1, D+32'h30,  1, D+32'h2C,  0);
      tbl[23] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h200, 1, D+32'h30,  0);
      tbl[24] = mk(1, 1, D+32'h300,   0, 0,   1, D+32'h204, 1, D+32'h200, 0);
      tbl[25] = mk(0, 0, 32'h0,       0, 0,   0, D,         1, 32'h0,     1);
      tbl[26] = mk(0, 0, 32'h0,       0, 0,   1, D,         0, 32'h0,     1);
      tbl[27] = mk(0, 0, 32'h0,       0, 0,   1, D+32'h04,  1, D,         0);

      rst = 1'b1;
      tick();
      tick();

      // Table: inputs for the coming edge, expectations for the current cycle.
      for (int i = 0; i < NV; i++) begin
         rst  = tbl[i].rst;
         br   = tbl[i].br;
         tgt  = tbl[i].tgt;
         stop = tbl[i].stop;
         ext  = tbl[i].ext;
         exp_out($sformatf("lsc1 row %0d", i), ce1, addr1, pc1, inst1, bub1,
                 tbl[i].ce, tbl[i].addr, tbl[i].pc_chk, tbl[i].pc, tbl[i].bub);
         tick();
      end

      // Re-reset everything for the LOAD_STALL_CYCLES=3 and wrap instances.
      br = 1'b0; stop = 1'b0; ext = 1'b0; tgt = 32'h0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_out("wrap boot", cew, addrw, pcw, instw, bubw, 0, 32'hFFFF_FFF8, 1, 32'h0, 1);
      exp_out("lsc3 boot", ce3, addr3, pc3, inst3, bub3, 0, D, 1, 32'h0, 1);
      tick();
      exp_out("wrap run0", cew, addrw, pcw, instw, bubw, 1, 32'hFFFF_FFF8, 0, 32'h0, 1);
      tick();
      exp_out("wrap run1", cew, addrw, pcw, instw, bubw, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
      tick();
      exp_out("wrap run2", cew, addrw, pcw, instw, bubw, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
      tick();
      exp_out("wrap run3", cew, addrw, pcw, instw, bubw, 1, 32'h0000_0004, 1, 32'h0000_0000, 0);
      repeat (5) tick();
      exp_out("lsc3 pre-stop", ce3, addr3, pc3, inst3, bub3, 1, D+32'h20, 1, D+32'h1C, 0);

      stop = 1'b1;
      tick();
      // Branch and stop during STALL must be ignored.
      stop = 1'b1; br = 1'b1; tgt = D+32'h300;
      exp_out("lsc3 bubble1", ce3, addr3, pc3, inst3, bub3, 1, D+32'h20, 0, 32'h0, 1);
      tick();
      stop = 1'b0; br = 1'b0; tgt = 32'h0;
      exp_out("lsc3 bubble2", ce3, addr3, pc3, inst3, bub3, 1, D+32'h20, 0, 32'h0, 1);
      ext = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_out($sformatf("lsc3 hold %0d", k), ce3, addr3, pc3, inst3, bub3,
                 1, D+32'h20, 0, 32'h0, 1);
      end
      ext = 1'b0;
      tick();
      exp_out("lsc3 bubble3", ce3, addr3, pc3, inst3, bub3, 1, D+32'h20, 0, 32'h0, 1);
      tick();
      exp_out("lsc3 resume", ce3, addr3, pc3, inst3, bub3, 1, D+32'h24, 1, D+32'h20, 0);

      // Reset in the middle of a STALL sequence.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      exp_out("lsc3 stall2 b1", ce3, addr3, pc3, inst3, bub3, 1, D+32'h24, 0, 32'h0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_out("lsc3 midreset", ce3, addr3, pc3, inst3, bub3, 0, D, 1, 32'h0, 1);
      tick();
      exp_out("lsc3 reboot run", ce3, addr3, pc3, inst3, bub3, 1, D, 0, 32'h0, 1);
      tick();
      exp_out("lsc3 refetch", ce3, addr3, pc3, inst3, bub3, 1, D+32'h04, 1, D, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
